// File: rtl/timer01_core.sv
// timer01_core: 8051 timer/counter 0 and 1 datapath.
//   Holds TMOD, TL0, TH0, TL1 and TH1, counts machine-cycle ticks or
//   falling edges on t0_pin/t1_pin, and emits one-clock overflow pulses
//   that the TCON owner turns into TF0/TF1.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   tick                one-clock pulse per machine cycle (qualifies all counting)
//   addr, data_in       SFR address / write data
//   wr_en, wr_bit_en    SFR write strobe; byte writes only when wr_bit_en = 0
//   tcon_data           TCON contents (bit4 = TR0, bit6 = TR1)
//   t0_pin, t1_pin      external count inputs
//   int0_n, int1_n      external interrupt pins, used for gating
//   tf0_set, tf1_set    registered one-clock overflow pulses
//   data_out            combinational read-back of the addressed SFR
module timer01_core #(
  parameter logic [7:0] ADDR_TMOD = 8'h89,
  parameter logic [7:0] ADDR_TL0  = 8'h8A,
  parameter logic [7:0] ADDR_TL1  = 8'h8B,
  parameter logic [7:0] ADDR_TH0  = 8'h8C,
  parameter logic [7:0] ADDR_TH1  = 8'h8D
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  input  logic       wr_bit_en,
  input  logic [7:0] tcon_data,
  input  logic       t0_pin,
  input  logic       t1_pin,
  input  logic       int0_n,
  input  logic       int1_n,
  output logic       tf0_set,
  output logic       tf1_set,
  output logic [7:0] data_out
);

  typedef struct packed {
    logic [7:0] tl;
    logic [7:0] th;
    logic       ovf;
  } step_t;

  // One counting step of a timer in modes 0-2; mode 3 holds here
  // (timer 0's split mode is handled separately).
  function automatic step_t count_step(input logic [1:0] mode,
                                       input logic [7:0] tl,
                                       input logic [7:0] th);
    step_t s;
    s.tl  = tl;
    s.th  = th;
    s.ovf = 1'b0;
    case (mode)
      2'd0: begin
        // 13-bit: TL[4:0] prescales TH, TL[7:5] is left untouched
        if (tl[4:0] == 5'h1F) begin
          s.tl  = {tl[7:5], 5'h00};
          s.th  = th + 8'd1;
          s.ovf = (th == 8'hFF);
        end else begin
          s.tl = {tl[7:5], tl[4:0] + 5'd1};
        end
      end
      2'd1: begin
        {s.th, s.tl} = {th, tl} + 16'd1;
        s.ovf        = ({th, tl} == 16'hFFFF);
      end
      2'd2: begin
        if (tl == 8'hFF) begin
          s.tl  = th;
          s.ovf = 1'b1;
        end else begin
          s.tl = tl + 8'd1;
        end
      end
      default: ;
    endcase
    return s;
  endfunction

  logic [7:0] tmod, tl0, th0, tl1, th1;
  logic       samp0, samp1;
  logic [7:0] tl0_nx, th0_nx, tl1_nx, th1_nx;
  logic       ovf0, ovf1, ovf_h0;
  step_t      step0, step1;

  logic wr_byte, wr_tmod, wr_tl0, wr_th0, wr_tl1, wr_th1;
  assign wr_byte = wr_en & ~wr_bit_en;
  assign wr_tmod = wr_byte & (addr == ADDR_TMOD);
  assign wr_tl0  = wr_byte & (addr == ADDR_TL0);
  assign wr_th0  = wr_byte & (addr == ADDR_TH0);
  assign wr_tl1  = wr_byte & (addr == ADDR_TL1);
  assign wr_th1  = wr_byte & (addr == ADDR_TH1);

  logic [1:0] mode0, mode1;
  logic       split, run0, run1, cnt0, cnt1;
  assign mode0 = tmod[1:0];
  assign mode1 = tmod[5:4];
  assign split = (mode0 == 2'd3);
  assign run0  = tcon_data[4] & (~tmod[3] | int0_n);
  assign run1  = tcon_data[6] & (~tmod[7] | int1_n);
  // Counter mode counts a 1->0 change between consecutive tick samples
  assign cnt0  = tick & run0 & (tmod[2] ? (samp0 & ~t0_pin) : 1'b1);
  assign cnt1  = tick & run1 & (tmod[6] ? (samp1 & ~t1_pin) : 1'b1);

  assign step0 = count_step(mode0, tl0, th0);
  assign step1 = count_step(mode1, tl1, th1);

  logic unused_tcon;
  assign unused_tcon = ^{tcon_data[7], tcon_data[5], tcon_data[3:0]};

  always_comb begin
    tl0_nx = tl0;
    th0_nx = th0;
    ovf0   = 1'b0;
    ovf_h0 = 1'b0;
    if (split) begin
      // TL0 keeps timer 0's controls; TH0 borrows TR1 as a plain timer
      if (cnt0) begin
        tl0_nx = tl0 + 8'd1;
        ovf0   = (tl0 == 8'hFF);
      end
      if (tick & tcon_data[6]) begin
        th0_nx = th0 + 8'd1;
        ovf_h0 = (th0 == 8'hFF);
      end
    end else if (cnt0) begin
      tl0_nx = step0.tl;
      th0_nx = step0.th;
      ovf0   = step0.ovf;
    end
  end

  always_comb begin
    tl1_nx = tl1;
    th1_nx = th1;
    ovf1   = 1'b0;
    if (cnt1) begin
      tl1_nx = step1.tl;
      th1_nx = step1.th;
      ovf1   = step1.ovf;
    end
  end

  // A write to any byte taking part in the wrap cancels the pulse:
  // modes 0/1 wrap across both bytes, mode 2 and split TL0 only via TL.
  logic sup0, sup1;
  assign sup0 = wr_tl0 | (~mode0[1] & wr_th0);
  assign sup1 = wr_tl1 | (~mode1[1] & wr_th1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmod    <= 8'h00;
      tl0     <= 8'h00;
      th0     <= 8'h00;
      tl1     <= 8'h00;
      th1     <= 8'h00;
      samp0   <= 1'b1;
      samp1   <= 1'b1;
      tf0_set <= 1'b0;
      tf1_set <= 1'b0;
    end else begin
      if (wr_tmod) tmod <= data_in;
      tl0 <= wr_tl0 ? data_in : tl0_nx;
      th0 <= wr_th0 ? data_in : th0_nx;
      tl1 <= wr_tl1 ? data_in : tl1_nx;
      th1 <= wr_th1 ? data_in : th1_nx;
      if (tick) begin
        samp0 <= t0_pin;
        samp1 <= t1_pin;
      end
      tf0_set <= ovf0 & ~sup0;
      // Timer 1 loses its flag to TH0 while timer 0 is split
      tf1_set <= (ovf1 & ~sup1 & ~split) | (ovf_h0 & ~wr_th0);
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (addr)
      ADDR_TMOD: data_out = tmod;
      ADDR_TL0:  data_out = tl0;
      ADDR_TL1:  data_out = tl1;
      ADDR_TH0:  data_out = th0;
      ADDR_TH1:  data_out = th1;
      default:   data_out = 8'h00;
    endcase
  end

endmodule
